// File: rtl/ddr_ctrl_pkg.sv
// Shared types and constants for the ddr_ctrl burst controller.
package ddr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP,
    DONE
  } state_t;

  localparam int         BEAT_W         = 4;
  localparam logic [7:0] ADDR_WRAP_MASK = 8'hFF;

endpackage

// File: rtl/ddr_ctrl.sv
// Burst controller: turns 1..16-beat read/write requests into single-word
// memory strobes, with handshaked write and read data streams.
module ddr_ctrl
  import ddr_ctrl_pkg::*;
#(
  parameter int T      = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [T-1:0]     req_addr,
  input  logic [3:0]       req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [T-1:0]     wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [T-1:0]     rd_data,
  output logic             done,
  output logic             mem_we,
  output logic             mem_re,
  output logic [T-1:0]     mem_addr,
  output logic [T-1:0]     mem_wdata,
  input  logic [T-1:0]     mem_rdata
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [T-1:0]      addr_q, addr_d, addr_nxt;
  logic [BEAT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [T-1:0]      rd_data_q, rd_data_d;
  logic              last_beat;

  // Only the low byte walks; the page bits above it stay pinned.
  assign addr_nxt  = {addr_q[T-1:8], (addr_q[7:0] + 8'd1) & ADDR_WRAP_MASK};
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    rd_data_d = rd_data_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = req_write ? WR_BEAT : RD_ISSUE;
        end
      end
      WR_BEAT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we    = write_q;
          mem_addr  = addr_q;
          mem_wdata = wr_data;
          addr_d    = addr_nxt;
          if (last_beat) state_d = DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      RD_ISSUE: begin
        mem_re   = ~write_q;
        mem_addr = addr_q;
        lat_d    = '0;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          rd_data_d = mem_rdata;
          state_d   = RD_RESP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RD_RESP: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          addr_d = addr_nxt;
          if (last_beat) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet the moment reset is asserted, not one edge later.
    if (!rstn) begin
      req_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      done      = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign rd_data = rd_data_q & {T{rstn}};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_ddr_ctrl.sv
// Self-checking bench for ddr_ctrl with a behavioural word memory and reference model.
module tb_ddr_ctrl;
  localparam int T = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [T-1:0] req_addr = '0;
  logic [3:0]   req_len = '0;
  logic         wr_valid = 1'b0;
  logic [T-1:0] wr_data = '0;
  logic         rd_ready = 1'b0;
  logic         req_ready, wr_ready, rd_valid, done, mem_we, mem_re;
  logic [T-1:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ddr_ctrl #(.T(T), .RD_LAT(1)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model (one-cycle read latency) and the bench's own expectation of it.
  logic [T-1:0] mem     [4096];
  logic [T-1:0] ref_mem [4096];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[11:0]];
  end

  int n_chk, n_pass;
  int we_n, re_n, done_n, collide_n, bus_err_n;
  logic [T-1:0] obs_waddr[$], obs_wdata[$], obs_raddr[$];

  always @(negedge clk) begin
    if (mem_we && mem_re) collide_n <= collide_n + 1;
    if (!mem_we && !mem_re && (mem_addr !== '0 || mem_wdata !== '0)) bus_err_n <= bus_err_n + 1;
    if (mem_re && mem_wdata !== '0) bus_err_n <= bus_err_n + 1;
    if (mem_we) begin
      we_n <= we_n + 1;
      obs_waddr.push_back(mem_addr);
      obs_wdata.push_back(mem_wdata);
    end
    if (mem_re) begin
      re_n <= re_n + 1;
      obs_raddr.push_back(mem_addr);
    end
    if (done) done_n <= done_n + 1;
  end

  function automatic logic [T-1:0] beat_addr(input logic [T-1:0] a, input int b);
    logic [7:0] lo;
    lo = a[7:0] + 8'(b);
    return {a[T-1:8], lo};
  endfunction

  // One complete burst; starts and ends just after a rising edge.
  task automatic run_burst(input bit wr, input logic [T-1:0] addr, input logic [3:0] len,
                           input int stall_beat, input int stall_n, input bit rnd, input int dbase);
    int beats, to, we0, re0, done0, bad, stl;
    logic [T-1:0] ea, d, exp_d, held;
    logic [T-1:0] dlist[16];
    beats = int'(len) + 1;
    we0 = we_n; re0 = re_n; done0 = done_n;
    obs_waddr.delete(); obs_wdata.delete(); obs_raddr.delete();
    if (!wr && !rnd) rd_ready = 1'b1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    to = 0; @(negedge clk);
    while (!req_ready && to < 50) begin @(negedge clk); to++; end
    n_chk++;
    if (!req_ready) begin
      $display("FAIL req_accept: req_ready=%0b after %0d cycles, want 1", req_ready, to);
      req_valid = 1'b0; return;
    end
    n_pass++;
    @(posedge clk); #1; req_valid = 1'b0;

    for (int b = 0; b < beats; b++) begin
      ea = beat_addr(addr, b);
      if (wr) begin
        d = (dbase >= 0) ? T'(dbase + b) : T'($urandom);
        dlist[b] = d;
        if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        wr_valid = 1'b1; wr_data = d;
        to = 0; @(negedge clk);
        while (!wr_ready && to < 20) begin @(negedge clk); to++; end
        n_chk++;
        if (!wr_ready) begin
          $display("FAIL wr_ready: beat %0d got 0, want 1", b);
          wr_valid = 1'b0; return;
        end
        n_pass++;
        @(posedge clk); #1; wr_valid = 1'b0;
        ref_mem[ea[11:0]] = d;
      end else begin
        exp_d = ref_mem[ea[11:0]];
        to = 0; @(negedge clk);
        while (!rd_valid && to < 20) begin @(negedge clk); to++; end
        n_chk++;
        if (!rd_valid) begin
          $display("FAIL rd_valid: beat %0d got 0, want 1", b); return;
        end
        n_pass++;
        n_chk++;
        if (rd_data !== exp_d)
          $display("FAIL rd_data: beat %0d addr %h got %h, want %h", b, ea, rd_data, exp_d);
        else n_pass++;
        stl = (b == stall_beat) ? stall_n : (rnd ? int'($urandom_range(0, 3)) : 0);
        if (stl > 0) begin
          rd_ready = 1'b0; held = rd_data; bad = 0;
          repeat (stl) begin
            @(negedge clk);
            if (!rd_valid || rd_data !== held || mem_re) bad++;
          end
          n_chk++;
          if (bad != 0)
            $display("FAIL rd_stall: %0d unstable cycles (valid=%0b data=%h re=%0b), want 0",
                     bad, rd_valid, rd_data, mem_re);
          else n_pass++;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        if (rnd) rd_ready = 1'b0;
      end
    end

    to = 0; @(negedge clk);
    while (!done && to < 20) begin @(negedge clk); to++; end
    n_chk++;
    if (!done) $display("FAIL done_pulse: done=0 after %0d cycles, want 1", to);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL done_gap: done=%0b req_ready=%0b, want 0/1", done, req_ready);
    else n_pass++;
    @(posedge clk); #1;

    n_chk++;
    if (done_n - done0 != 1) $display("FAIL done_count: got %0d, want 1", done_n - done0);
    else n_pass++;
    n_chk++;
    if (wr ? (we_n - we0 != beats || re_n != re0) : (re_n - re0 != beats || we_n != we0))
      $display("FAIL strobe_count: we=%0d re=%0d, want %0d beats of %s", we_n - we0, re_n - re0,
               beats, wr ? "we" : "re");
    else n_pass++;
    bad = 0;
    for (int b = 0; b < beats; b++) begin
      if (wr) begin
        if (b >= obs_waddr.size() || obs_waddr[b] !== beat_addr(addr, b) || obs_wdata[b] !== dlist[b])
          bad++;
      end else if (b >= obs_raddr.size() || obs_raddr[b] !== beat_addr(addr, b)) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL mem_bus: %0d beats with wrong addr/data (base %h len %0d), want 0",
                           bad, addr, len);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, wr_ready, rd_valid, rd_data, done, mem_we, mem_re, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_outputs: req_ready=%0b mem_addr=%h rd_data=%h, want all 0",
               req_ready, mem_addr, rd_data);
    else n_pass++;
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL reset_release: req_ready=%0b, want 1", req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_basic();
    int bad = 0;
    run_burst(1'b1, 32'h10, 4'd3, -1, 0, 1'b0, 'hA0);
    for (int i = 0; i < 4; i++) if (mem[12'h10 + 12'(i)] !== T'('hA0 + i)) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL write_mem: %0d words wrong at 0x10..0x13, want A0..A3", bad);
    else n_pass++;
  endtask

  task automatic test_read_basic();
    run_burst(1'b0, 32'h10, 4'd3, -1, 0, 1'b0, -1);
  endtask

  task automatic test_wrap();
    run_burst(1'b1, 32'hAFE, 4'd2, -1, 0, 1'b0, 'h55);
    n_chk++;
    if (obs_waddr.size() != 3 || obs_waddr[0] !== 32'hAFE || obs_waddr[1] !== 32'hAFF ||
        obs_waddr[2] !== 32'hA00)
      $display("FAIL addr_wrap: %0d strobes, want AFE,AFF,A00", obs_waddr.size());
    else n_pass++;
  endtask

  task automatic test_read_stall();
    run_burst(1'b1, 32'h40, 4'd3, -1, 0, 1'b0, 'h700);
    run_burst(1'b0, 32'h40, 4'd3, 1, 5, 1'b0, -1);
  endtask

  task automatic test_reset_midburst();
    int to, we0, done0;
    logic [T-1:0] old;
    old = mem[12'h302];
    we0 = we_n; done0 = done_n;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_len = 4'd7;
    to = 0; @(negedge clk);
    while (!req_ready && to < 20) begin @(negedge clk); to++; end
    @(posedge clk); #1; req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = T'(32'hBEEF0 + b);
      @(posedge clk); #1;
      ref_mem[12'h300 + 12'(b)] = T'(32'hBEEF0 + b);
    end
    wr_data = 32'hDEAD; rstn = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req_ready, wr_ready, rd_valid, rd_data, done, mem_we, mem_re, mem_addr, mem_wdata} !== '0)
      $display("FAIL abort_outputs: mem_we=%0b mem_addr=%h wr_ready=%0b, want all 0",
               mem_we, mem_addr, wr_ready);
    else n_pass++;
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req_ready, wr_ready, done, mem_we, mem_re, mem_addr} !== '0)
      $display("FAIL abort_hold: req_ready=%0b mem_we=%0b, want 0/0", req_ready, mem_we);
    else n_pass++;
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL abort_release: req_ready=%0b, want 1", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (we_n - we0 != 2 || done_n != done0 || mem[12'h302] !== old)
      $display("FAIL abort_effects: we=%0d done=%0d mem302=%h, want 2/0/%h",
               we_n - we0, done_n - done0, mem[12'h302], old);
    else n_pass++;
  endtask

  task automatic test_stalled_request();
    int to, early, done0, we0;
    logic [T-1:0] d;
    d = 32'h5A5A_0600;
    done0 = done_n; we0 = we_n; early = 0;
    rd_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_len = 4'd1;
    to = 0; @(negedge clk);
    while (!req_ready && to < 20) begin @(negedge clk); to++; end
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'h600; req_len = 4'd0;
    wr_valid = 1'b1; wr_data = d;
    to = 0; @(negedge clk);
    while (!done && to < 40) begin
      if (req_ready) early++;
      @(negedge clk); to++;
    end
    n_chk++;
    if (!done || early != 0)
      $display("FAIL req_stall: done=%0b ready-during-burst=%0d, want 1/0", done, early);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL b2b_gap: req_ready=%0b after done, want 1", req_ready);
    else n_pass++;
    @(posedge clk); #1; req_valid = 1'b0;
    to = 0; @(negedge clk);
    while (!done && to < 20) begin @(negedge clk); to++; end
    @(posedge clk); #1; wr_valid = 1'b0;
    ref_mem[12'h600] = d;
    n_chk++;
    if (mem[12'h600] !== d || done_n - done0 != 2 || we_n - we0 != 1)
      $display("FAIL pending_req: mem600=%h done=%0d we=%0d, want %h/2/1",
               mem[12'h600], done_n - done0, we_n - we0, d);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [T-1:0] a;
    for (int i = 0; i < 350; i++) begin
      a = {20'h0, 4'($urandom_range(0, 3)), 8'($urandom)};
      run_burst(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), -1, 0, 1'b1, -1);
    end
  endtask

  task automatic test_protocol();
    n_chk++;
    if (collide_n != 0) $display("FAIL we_re_overlap: %0d cycles, want 0", collide_n);
    else n_pass++;
    n_chk++;
    if (bus_err_n != 0) $display("FAIL idle_bus: %0d cycles with stray addr/data, want 0", bus_err_n);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] <= '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_read_stall();
    test_reset_midburst();
    test_stalled_request();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_ctrl.md
DDR_CTRL -- requirements
Module: ddr_ctrl

Interface
REQ-001 Parameter T, default 32: data and address width.
REQ-002 Parameter RD_LAT, default 1: cycles from mem_re asserted to mem_rdata valid.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  burst request offered.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 req_write  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  T  start word address.
REQ-009 req_len  input  4  beats minus one (0..15 means 1..16 beats).
REQ-010 wr_valid / wr_ready  input / output  1 each  write-data handshake.
REQ-011 wr_data  input  T  write beat data.
REQ-012 rd_valid / rd_ready  output / input  1 each  read-data handshake.
REQ-013 rd_data  output  T  read beat data.
REQ-014 done  output  1  one-cycle pulse after the last beat of a burst.
REQ-015 mem_we, mem_re  output  1 each  memory write and read strobes.
REQ-016 mem_addr  output  T  memory word address.
REQ-017 mem_wdata  output  T  memory write data.
REQ-018 mem_rdata  input  T  memory read data.

Function
REQ-019 FSM states SHALL be IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RD_RESP and DONE.
REQ-020 req_ready SHALL be 1 only in IDLE; on acceptance, latch req_write, req_addr and req_len, then go to WR_BEAT (write) or RD_ISSUE (read) next cycle.
REQ-021 WR_BEAT: wr_ready = 1; on a wr_valid && wr_ready cycle, drive mem_we = 1, mem_addr = current address and mem_wdata = wr_data in that same cycle (combinational), then advance address and beat count; no wr_valid means no strobe.
REQ-022 RD_ISSUE: drive mem_re = 1 for exactly one cycle at the current address, then go to RD_WAIT.
REQ-023 RD_WAIT: count RD_LAT cycles, capture mem_rdata into rd_data, then go to RD_RESP.
REQ-024 RD_RESP: hold rd_valid = 1 with rd_data stable until rd_ready; on handshake, advance the address and either return to RD_ISSUE or, after the last beat, go to DONE.
REQ-025 After the last write beat, go to DONE; DONE asserts done for one cycle and returns to IDLE.
REQ-026 Address advance: the low 8 bits SHALL increment modulo 256 (0xFF wraps to 0x00); bits T-1:8 SHALL hold their latched value.
REQ-027 mem_we and mem_re SHALL never be high in the same cycle.
REQ-028 Outside WR_BEAT and RD_ISSUE, mem_we, mem_re, mem_addr and mem_wdata SHALL be 0.
REQ-029 wr_ready and rd_valid SHALL be 0 outside WR_BEAT and RD_RESP respectively.
REQ-030 A new request presented during a burst SHALL stall (req_ready = 0) and SHALL NOT be lost; it is accepted in the next IDLE cycle.
REQ-031 Back-to-back bursts: the minimum gap from done to the next req_ready is 0 cycles (IDLE follows DONE).

Reset
REQ-032 When rstn = 0 at a rising edge, the FSM SHALL go to IDLE and clear the beat counter, latched address and rd_data.
REQ-033 Every output SHALL be 0 during reset, except req_ready, which SHALL be 0 while rstn = 0 and become 1 in the first cycle after release.
REQ-034 Reset mid-burst SHALL abort the burst with no further strobes and no done pulse.

Structure
REQ-035 A shared package ddr_ctrl_pkg SHALL hold the state enum, the BEAT_W = 4 constant and the ADDR_WRAP_MASK = 8'hFF constant.
REQ-036 The RTL SHALL be a single module with no sub-modules; the RD_LAT counter is inline.
REQ-037 Benches SHALL pair ddr_ctrl with the team's existing ddr memory model, using RD_LAT = 1.

Verification
REQ-038 Write with addr 0x10 and len 3, then data A0..A3 -> mem[0x10..0x13] = A0..A3, 4 mem_we pulses, 1 done pulse.
REQ-039 Read with addr 0x10 and len 3, rd_ready held high -> rd_data sequence A0..A3, mem_re count 4.
REQ-040 Write with addr 0xFE and len 2 -> mem_addr sequence 0xFE, 0xFF, 0x00; upper bits unchanged.
REQ-041 Read with rd_ready low for 5 cycles on beat 1 -> rd_valid and rd_data held stable, no extra mem_re issued.
REQ-042 Reset asserted during beat 2 of a len 7 write -> all outputs 0 next cycle, no done pulse, req_ready = 1 after release.
REQ-043 Random mixed bursts for 10k cycles -> mem_we && mem_re never both high; read data always matches the last write to that address.
